mix_columns_iter: RTL and testbench

MIX_COLUMNS_ITER -- requirements
Module: mix_columns_iter

---
 rtl/mix_columns_iter.sv | 135 +++++++++++++
 tb/tb_mix_columns_iter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_iter.sv
// mix_columns_iter: iterative AES MixColumns stage with valid/ready handshakes.
//
// Accepts a 128-bit column-major AES state and applies MixColumns to
// COLS_PER_CYCLE columns per clock. A state flagged in_last (final round)
// is passed through untransformed.
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream state valid
//   in_ready   block can accept a state this cycle
//   in_data    AES state; column c = [127-32c -: 32], row r = [127-32c-8r -: 8]
//   in_last    final-round flag sampled with in_data (1 = bypass MixColumns)
//   out_valid  out_data holds a completed state
//   out_ready  downstream accepts
//   out_data   result state, same layout as in_data
//   busy       block is not idle
module mix_columns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    // With four columns per cycle the step wraps to 0, keeping idx at 0.
    localparam logic [1:0] STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_OFF = 2'(COLS_PER_CYCLE - 1);

    logic [1:0]   state_q, state_d;
    logic [1:0]   idx_q, idx_d;
    logic [127:0] work_q, work_d;
    logic         last_q, last_d;
    logic [127:0] calc;
    logic         accept;

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] a);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = a[31:24];
        a1 = a[23:16];
        a2 = a[15:8];
        a3 = a[7:0];
        b0 = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
        b3 = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
        return {b0, b1, b2, b3};
    endfunction

    assign in_ready  = (state_q == IDLE) || (state_q == DONE && out_ready);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = work_q;
    assign accept    = in_valid && in_ready;

    // Working buffer with the current column window replaced by its transform.
    always_comb begin
        logic [1:0] off;
        calc = work_q;
        off  = 2'd0;
        for (int c = 0; c < 4; c++) begin
            off = 2'(c) - idx_q;
            if ({30'd0, off} < 32'(COLS_PER_CYCLE)) begin
                calc[127-32*c -: 32] = mix_col(work_q[127-32*c -: 32]);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        work_d  = work_q;
        last_d  = last_q;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    work_d  = in_data;
                    last_d  = in_last;
                    idx_d   = 2'd0;
                    state_d = in_last ? DONE : CALC;
                end else if (state_q == DONE && out_ready) begin
                    state_d = IDLE;
                end
            end
            CALC: begin
                // A bypassed state never enters CALC; the guard keeps it untouched anyway.
                if (!last_q) begin
                    work_d = calc;
                    idx_d  = idx_q + STEP;
                    if (idx_q + LAST_OFF == 2'd3) begin
                        state_d = DONE;
                    end
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= 2'd0;
            work_q  <= 128'h0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            work_q  <= work_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_mix_columns_iter.sv
// Testbench for mix_columns_iter: three instances (1, 2 and 4 columns per cycle)
// checked against a GF(2^8) matrix-multiply reference model.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] in_data   [3];
    logic         in_last   [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] out_data  [3];
    logic         busy      [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mix_columns_iter #(
            .COLS_PER_CYCLE(1 << g)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_data  (in_data[g]),
            .in_last  (in_last[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g]),
            .busy     (busy[g])
        );
    end

    // Generic GF(2^8) multiply by shift-and-add.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Circulant matrix rows (2 3 1 1) rotated right by row number.
    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic last);
        logic [127:0] r;
        logic [31:0]  coefs;
        logic [7:0]   acc;
        int           k;
        if (last) return s;
        coefs = 32'h02030101;
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) begin
                    k = (j - row + 4) % 4;
                    acc = acc ^ gmul(s[127-32*c-8*j -: 8], coefs[31-8*k -: 8]);
                end
                r[127-32*c-8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Count edges after the accepting edge until out_valid is seen (bounded).
    task automatic wait_valid(input int k, output int n);
        n = 0;
        while (out_valid[k] !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    // One isolated transaction on instance k with out_ready held high.
    task automatic run_one(input int k, input logic [127:0] d, input logic last,
                           input int lat, input logic [127:0] exp, input string tag);
        int n;
        in_data[k]   = d;
        in_last[k]   = last;
        in_valid[k]  = 1'b1;
        out_ready[k] = 1'b1;
        #1;
        check_bit({tag, "_in_ready"}, in_ready[k], 1'b1);
        tick();
        in_valid[k] = 1'b0;
        in_data[k]  = ~d;     // no handshake: must not disturb the state in flight
        in_last[k]  = ~last;
        wait_valid(k, n);
        check_int({tag, "_latency"}, n, lat);
        check_vec({tag, "_data"}, out_data[k], exp);
        tick();
        check_bit({tag, "_idle_valid"}, out_valid[k], 1'b0);
        check_bit({tag, "_idle_busy"}, busy[k], 1'b0);
    endtask

    initial begin
        logic [127:0] d, held, nd;
        logic [127:0] exp_q[$];
        logic [127:0] e;
        int           n, sent, got;
        logic         acc, ohs;

        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            in_last[k]   = 1'b0;
            out_ready[k] = 1'b0;
        end
        #12;
        check_bit("rst_in_ready", in_ready[0], 1'b1);
        check_bit("rst_out_valid", out_valid[0], 1'b0);
        check_bit("rst_busy", busy[0], 1'b0);
        check_vec("rst_out_data", out_data[0], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Scenario 1: FIPS-197 column example.
        run_one(0, 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 4,
                128'h046681e5e0cb199a48f8d37a2806264c, "s1");

        // Scenario 2: known columns for every width.
        for (int k = 0; k < 3; k++) begin
            run_one(k, 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 4 >> k,
                    128'h8e4da1bc9fdc589d01010101c6c6c6c6, $sformatf("s2_w%0d", 1 << k));
        end
        check_vec("s2_model", ref_model(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0),
                  128'h8e4da1bc9fdc589d01010101c6c6c6c6);

        // Scenario 3: final-round bypass visible right after the accepting edge.
        d = 128'hd4d4d4d52d26314c00112233aabbccdd;
        run_one(0, d, 1'b1, 0, d, "s3");
        run_one(2, d, 1'b1, 0, d, "s3_w4");

        // Scenario 4: output stall, then simultaneous output and input handshakes.
        d = $urandom();
        d = {d[31:0], 32'($urandom()), 32'($urandom()), 32'($urandom())};
        in_data[0]   = d;
        in_last[0]   = 1'b0;
        in_valid[0]  = 1'b1;
        out_ready[0] = 1'b0;
        tick();
        nd = {32'($urandom()), 32'($urandom()), 32'($urandom()), 32'($urandom())};
        in_data[0] = nd;    // held upstream, not accepted while busy
        wait_valid(0, n);
        check_int("s4_latency", n, 4);
        held = out_data[0];
        check_vec("s4_data", held, ref_model(d, 1'b0));
        for (int i = 0; i < 5; i++) begin
            tick();
            check_vec($sformatf("s4_hold_data%0d", i), out_data[0], held);
            check_bit($sformatf("s4_hold_valid%0d", i), out_valid[0], 1'b1);
            check_bit($sformatf("s4_hold_ready%0d", i), in_ready[0], 1'b0);
        end
        out_ready[0] = 1'b1;
        #1;
        check_bit("s4_release_ready", in_ready[0], 1'b1);
        tick();
        in_valid[0] = 1'b0;
        check_bit("s4_reload_valid", out_valid[0], 1'b0);
        check_bit("s4_reload_busy", busy[0], 1'b1);
        wait_valid(0, n);
        check_int("s4_second_latency", n, 4);
        check_vec("s4_second_data", out_data[0], ref_model(nd, 1'b0));
        tick();
        check_bit("s4_idle", busy[0], 1'b0);

        // Scenario 5: reset during the second CALC cycle.
        in_data[0]  = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        in_last[0]  = 1'b0;
        in_valid[0] = 1'b1;
        tick();
        in_valid[0] = 1'b0;
        tick();
        check_bit("s5_busy_before", busy[0], 1'b1);
        rst = 1'b1;
        #1;
        check_bit("s5_rst_valid", out_valid[0], 1'b0);
        check_vec("s5_rst_data", out_data[0], 128'h0);
        check_bit("s5_rst_ready", in_ready[0], 1'b1);
        check_bit("s5_rst_busy", busy[0], 1'b0);
        #1;
        rst = 1'b0;
        d = {32'($urandom()), 32'($urandom()), 32'($urandom()), 32'($urandom())};
        run_one(0, d, 1'b0, 4, ref_model(d, 1'b0), "s5_after");

        // Scenario 6: random stream with random stalls, checked in order.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 400 && got < 8; cyc++) begin
            if (in_valid[0] !== 1'b1 && sent < 8) begin
                in_data[0]  = {32'($urandom()), 32'($urandom()), 32'($urandom()),
                               32'($urandom())};
                in_last[0]  = 1'($urandom_range(0, 1));
                in_valid[0] = 1'b1;
            end
            out_ready[0] = 1'($urandom_range(0, 1));
            #1;
            acc = in_valid[0] && in_ready[0];
            ohs = out_valid[0] && out_ready[0];
            if (ohs) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
                check_vec($sformatf("s6_result%0d", got), out_data[0], e);
                got++;
            end
            if (acc) begin
                exp_q.push_back(ref_model(in_data[0], in_last[0]));
                sent++;
            end
            tick();
            if (acc) in_valid[0] = 1'b0;
        end
        check_int("s6_received", got, 8);
        check_int("s6_leftover", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
